// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between the I/O register bank and the countdown
// controller. The master drives control pulses, the slave drives BCD digits
// and status flags.
interface countdown_ctrl_if;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic       busy;
  logic       running;
  logic       expired;
  logic       expire_pulse;

  modport master (
    output load, load_val, start, pause, clear,
    input  ones, tens, hundreds, busy, running, expired, expire_pulse
  );

  modport slave (
    input  load, load_val, start, pause, clear,
    output ones, tens, hundreds, busy, running, expired, expire_pulse
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Countdown-timer controller: converts an 8-bit seconds value to three BCD
// digits by sequential double-dabble, then counts down once per TICK_DIV
// cycles under start/pause/clear control and flags expiry.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  countdown_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic [3:0]    r_hund;
  logic [PW-1:0] r_presc;
  logic [19:0]   r_dd;
  logic [2:0]    r_cnt;
  logic          r_expire_pulse;

  logic [19:0]   w_dd_adj;
  logic [19:0]   w_dd_next;
  logic [3:0]    w_dec_ones;
  logic [3:0]    w_dec_tens;
  logic [3:0]    w_dec_hund;
  logic          w_tick;
  logic          w_nonzero;
  logic          w_last;

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    w_dd_adj = r_dd;
    for (int unsigned n = 0; n < 3; n++) begin
      if (r_dd[8 + 4*n +: 4] >= 4'd5)
        w_dd_adj[8 + 4*n +: 4] = r_dd[8 + 4*n +: 4] + 4'd3;
    end
    w_dd_next = w_dd_adj << 1;
  end

  // BCD decrement with borrow ripple ones -> tens -> hundreds.
  always_comb begin
    w_dec_ones = r_ones - 4'd1;
    w_dec_tens = r_tens;
    w_dec_hund = r_hund;
    if (r_ones == 4'd0) begin
      w_dec_ones = 4'd9;
      if (r_tens == 4'd0) begin
        w_dec_tens = 4'd9;
        w_dec_hund = r_hund - 4'd1;
      end else begin
        w_dec_tens = r_tens - 4'd1;
      end
    end
  end

  assign w_tick    = (r_presc == PRESC_TOP);
  assign w_nonzero = |{r_hund, r_tens, r_ones};
  assign w_last    = (r_hund == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

  // Controller FSM: conversion sequencing, prescaler, countdown and expiry strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ones         <= '0;
      r_tens         <= '0;
      r_hund         <= '0;
      r_presc        <= '0;
      r_dd           <= '0;
      r_cnt          <= '0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_expire_pulse <= 1'b0;
      if (bus.clear) begin
        r_state <= S_IDLE;
        r_ones  <= '0;
        r_tens  <= '0;
        r_hund  <= '0;
        r_presc <= '0;
        r_dd    <= '0;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_CONV: begin
            r_dd <= w_dd_next;
            if (r_cnt == 3'd7) begin
              r_hund  <= w_dd_next[19:16];
              r_tens  <= w_dd_next[15:12];
              r_ones  <= w_dd_next[11:8];
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
          S_RUN: begin
            // The prescaler advances on the pause edge too; the held value is
            // what resumes after start.
            if (w_tick) begin
              r_presc <= '0;
              r_ones  <= w_dec_ones;
              r_tens  <= w_dec_tens;
              r_hund  <= w_dec_hund;
              if (w_last) begin
                r_state        <= S_DONE;
                r_expire_pulse <= 1'b1;
              end else if (bus.pause) begin
                r_state <= S_PAUSED;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
              if (bus.pause)
                r_state <= S_PAUSED;
            end
          end
          default: begin
            // IDLE, PAUSED and DONE all accept a new load.
            if (bus.load) begin
              r_dd    <= {12'd0, bus.load_val};
              r_cnt   <= '0;
              r_state <= S_CONV;
            end else if (bus.start) begin
              if (r_state == S_IDLE && w_nonzero) begin
                r_presc <= '0;
                r_state <= S_RUN;
              end else if (r_state == S_PAUSED) begin
                r_state <= S_RUN;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.ones         = r_ones;
  assign bus.tens         = r_tens;
  assign bus.hundreds     = r_hund;
  assign bus.busy         = (r_state == S_CONV);
  assign bus.running      = (r_state == S_RUN);
  assign bus.expired      = (r_state == S_DONE);
  assign bus.expire_pulse = r_expire_pulse;

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown-timer controller that feeds the three-digit seven-segment display driver with BCD digits. It accepts an 8-bit binary seconds value and converts it to BCD sequentially. It then counts down once per prescaled tick under start/pause/clear control and flags expiry. It sits between the processor's I/O register bank and the display driver, whose `ones`/`tens`/`hundreds` inputs it drives directly.

## Interface
- `TICK_DIV`, default 100000000: clk cycles per countdown tick (1 Hz at 100 MHz); ≥2; benches use 4.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle pulse; capture `load_val` and begin binary-to-BCD conversion.
- `load_val`  in  8  seconds to load, binary 0–255.
- `start`  in  1  one-cycle pulse; begin or resume counting.
- `pause`  in  1  one-cycle pulse; freeze counting.
- `clear`  in  1  one-cycle pulse; abort anything, digits to 0.
- `ones`, `tens`, `hundreds`  out  4 each  BCD digits, always 0–9.
- `busy`  out  1  high during conversion.
- `running`  out  1  high in RUN.
- `expired`  out  1  high in DONE.
- `expire_pulse`  out  1  single-cycle strobe on reaching 000.

## Operation
- States: IDLE, CONV, RUN, PAUSED, DONE. Reset → IDLE, all digits 0, prescaler 0, all flag outputs 0.
- Input priority when simultaneous: clear > load > start > pause.
- clear in any state → IDLE, digits 000, prescaler 0, conversion abandoned.
- load accepted in IDLE, PAUSED, DONE → CONV. Ignored in RUN and CONV.
- CONV: double-dabble (add 3 to any BCD nibble ≥5, then shift) over exactly 8 cycles in an internal 20-bit register. Displayed digits keep their old value until the commit edge. Then → IDLE.
- IDLE: start with digits ≠ 000 → RUN with prescaler cleared. start with 000 is ignored.
- RUN: prescaler increments each cycle. At TICK_DIV−1 it wraps to 0 and the BCD value decrements by one. ones 0→9 borrows from tens; tens 0→9 borrows from hundreds.
- Decrement producing 000 → DONE with `expire_pulse` for that one cycle.
- pause in RUN → PAUSED with the prescaler held.
- tick coinciding with pause: the decrement still applies, then → PAUSED. If that decrement reaches 000, → DONE instead.
- PAUSED: start → RUN, prescaler resumes from its held value. pause is ignored.
- DONE: digits stay 000, `expired`=1. start and pause are ignored.
- Outputs are registered. `running`/`busy`/`expired` are pure decodes of the registered state.

## Timing
- load sampled at edge N: `busy`=1 after N through N+8. Digits update and `busy` falls at edge N+8 (8 cycles of latency).
- start sampled at edge N: `running`=1 after N. First decrement at edge N+TICK_DIV, then every TICK_DIV cycles.
- After pause at edge P with prescaler value k, and resume at edge R: next decrement at edge R+(TICK_DIV−k).
- `expire_pulse` is high exactly one cycle, asserted on the same edge that digits become 000 and `expired` rises.
- clear takes effect on the sampling edge. Reset mid-conversion or mid-count forces reset values asynchronously, with no partial digit update.
- Max value 255 → 2,5,5; 0 → 0,0,0. Digits never exceed 9 in any cycle.

## Test plan
- Reset, then load 8'd255 → `busy` high 8 cycles, then hundreds/tens/ones = 2/5/5, state IDLE. Repeat for 0 → 0/0/0 and 100 → 1/0/0.
- Load 10, start, TICK_DIV=4 → digits 0/0/9 at start+4, 0/0/8 at start+8, …, 000 at start+40. `expire_pulse` one cycle then, `expired` held, `running` low.
- Load 100, start, run one tick → 0/9/9, checking the double borrow. Next tick → 0/9/8.
- Load 5, start, pause 2 cycles after start, wait 20 cycles → digits unchanged. start → decrement exactly 2 cycles later.
- Simultaneous events: clear+load → 000 in IDLE with `busy` low. Tick+pause → decrement applied and PAUSED. load during RUN → ignored. start with 000 in IDLE → stays IDLE.
- Assert `rst` mid-CONV and mid-RUN → all outputs 0 immediately. After release, load 42 → 0/4/2.
